cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Two-port arbiter that shares the CPU's single memory bus between the data cache (port A) and the instruction cache (port B). It sits between the two cache controllers and the system bus and uses the same request/ready handshake on every side. A grant is held for as long as the granted requester keeps `request` high, so multi-transfer sequences stay atomic on the bus: a dirty-line write-back followed by a refill read, with request held across the `ready` in between. A bus watchdog converts a hung transfer into a completed one and latches a fault.

## Interface
- `TIMEOUT`, default 1024: bus-wait cycles before watchdog fires; 0 disables the watchdog.
- `FAULT_RDATA`, default 32'h0000_0000: read data returned on a watchdog completion.

- `i_clock`  in  1  single clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `i_pa_rw`, `i_pa_request`, `i_pa_address[31:0]`, `i_pa_wdata[31:0]`  in: port A (DCache) request.
- `o_pa_ready`  out  1, `o_pa_rdata`  out  32: port A response.
- `i_pb_rw`, `i_pb_request`, `i_pb_address[31:0]`, `i_pb_wdata[31:0]`  in: port B (ICache) request.
- `o_pb_ready`  out  1, `o_pb_rdata`  out  32: port B response.
- `o_bus_rw`, `o_bus_request`  out  1: bus control.
- `o_bus_address`, `o_bus_wdata`  out  32: bus address and write data.
- `i_bus_ready`  in  1, `i_bus_rdata`  in  32: bus response.
- `o_fault`  out  1: sticky watchdog fault.
- `o_fault_address`  out  32: bus address of the first faulting transfer.
- `i_fault_clear`  in  1: synchronous clear of `o_fault` and `o_fault_address`.

## Operation
- States: IDLE, GRANT_A, GRANT_B. Grant is a registered state. Bus outputs are a combinational mux of the granted port's inputs.
- IDLE: all bus outputs 0. The arbitration winner is registered, and the winner's state is entered on the next edge.
- GRANT_x:
  - Bus signals are driven from port x.
  - `o_bus_request` follows `i_px_request`.
  - `o_px_rdata` = `i_bus_rdata`.
  - `o_px_ready` = `i_bus_ready`.
- The non-granted port always sees ready 0 and rdata 0.
- Leaving GRANT_x: when `i_px_request` is 0, the arbiter re-arbitrates in the same cycle.
  - If the other port is requesting, go directly to its grant state.
  - Otherwise go to IDLE.
- Back-to-back transfers: while `i_px_request` stays 1 after a `ready`, the grant is held and the new address/rw pass through unchanged.
- Watchdog:
  - The counter resets on a grant change and on every `i_bus_ready`.
  - It increments while `o_bus_request`=1 and `i_bus_ready`=0.
  - When it reaches `TIMEOUT`, the arbiter pulses `o_px_ready`=1 for one cycle with `o_px_rdata`=`FAULT_RDATA` instead of the bus ready.
  - It sets `o_fault`. It captures `o_fault_address` only if `o_fault` was 0.
  - The counter then resets.
- `i_fault_clear` has priority over a simultaneous new fault; the new fault is dropped.

## Timing
- Reset values: state IDLE; all `o_bus_*`, `o_pa_*`, `o_pb_*` 0; `o_fault` 0; `o_fault_address` 0; watchdog 0; round-robin pointer favours A.
- Reset mid-transfer: outputs drop to 0 asynchronously; the bus slave must tolerate request loss.
- Grant latency from IDLE: request in cycle N, bus request in cycle N+1.
- Handover latency: 0 cycles. A port drops its request in cycle N; the other port's request is on the bus in cycle N.
- Ready/rdata path is combinational, with zero added latency.
- Simultaneous requests in IDLE resolve by the arbitration policy (see Configuration).
- A request dropped by a port before it is granted is ignored, with no side effects.
- Watchdog firing at `TIMEOUT` cycles of waiting: a fault `ready` appears in wait cycle `TIMEOUT`+1.

## Configuration
- `CPU_BUS_ARBITER_ROUND_ROBIN_EN` defined:
  - On a simultaneous-request tie, grant goes to the port that was not granted most recently.
  - The pointer updates on every grant entry.
- Undefined: fixed priority, with port A (DCache) always winning ties. No pointer register is built.

## Test plan
- Single port A read at 0x0000_1000: bus request at cycle+1, slave ready after 3 cycles with rdata 0x1234_5678 -> `o_pa_ready` for 1 cycle, `o_pa_rdata`=0x1234_5678, `o_pb_ready` stays 0.
- Port A write-back to 0x2000 then read of 0x3000 with request held across the ready, while port B requests throughout -> both A transfers complete before any port B address appears on the bus.
- Port A drops request in cycle N while port B is pending at 0x0400 -> `o_bus_address`=0x0400 in cycle N, with no IDLE cycle.
- Simultaneous A and B requests, three rounds:
  - With ROUND_ROBIN_EN: grants A, B, A.
  - Without: grants A, A, A.
- `TIMEOUT`=8, slave never ready, port B read at 0xDEAD_0000 -> `o_pb_ready` pulses in wait cycle 9 with rdata 0, `o_fault`=1, `o_fault_address`=0xDEAD_0000. A later fault keeps that address. `i_fault_clear` returns both to 0.
- `i_reset` asserted low mid-grant -> all outputs 0 immediately; after release, a port B-only request is granted normally.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the CPU memory bus between the data cache (port A)
// and the instruction cache (port B). A grant is held while the owner keeps
// its request high, and a bus watchdog turns hung transfers into completions.
// Optional feature macro: CPU_BUS_ARBITER_ROUND_ROBIN_EN. When it is defined,
// ties go to the port not granted most recently. When it is undefined, port A
// has fixed priority.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [31:0] FAULT_RDATA = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_rw,
  input  logic        i_pa_request,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic        o_pa_ready,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic        o_pb_ready,
  output logic [31:0] o_pb_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_fault,
  output logic [31:0] o_fault_address,
  input  logic        i_fault_clear
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  // The counter must be able to hold TIMEOUT itself.
  localparam int unsigned    WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  state_e            gnt;        // port actually driving the bus this cycle
  state_e            winner;     // arbitration result used from IDLE
  logic              favour_b;   // tie-break: 1 hands a tie to port B
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_base;
  logic              wd_fire;
  logic              fault_q, fault_d;
  logic [31:0]       fault_addr_q, fault_addr_d;

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign favour_b = rr_q;

  // Point the tie-break away from whichever port was just granted.
  always_comb begin
    rr_d = rr_q;
    if ((state_d != state_q) && (state_d != IDLE)) begin
      rr_d = (state_d == GRANT_A);
    end
  end

  // Round-robin pointer register; reset favours port A.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign favour_b = 1'b0;
`endif

  // Effective grant: hold while requested; on a drop, hand over in the same cycle.
  always_comb begin
    gnt = IDLE;
    case (state_q)
      GRANT_A: begin
        if (i_pa_request)      gnt = GRANT_A;
        else if (i_pb_request) gnt = GRANT_B;
      end
      GRANT_B: begin
        if (i_pb_request)      gnt = GRANT_B;
        else if (i_pa_request) gnt = GRANT_A;
      end
      default: gnt = IDLE;
    endcase
  end

  // Arbitration winner from IDLE; simultaneous requests use the tie-break.
  always_comb begin
    winner = IDLE;
    if (i_pa_request && i_pb_request) winner = favour_b ? GRANT_B : GRANT_A;
    else if (i_pa_request)            winner = GRANT_A;
    else if (i_pb_request)            winner = GRANT_B;
  end

  // Next state: register the winner from IDLE, otherwise follow the live grant.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = winner;
    else                 state_d = gnt;
  end

  // Watchdog: restart on grant change or ready, fire once the wait reaches TIMEOUT.
  always_comb begin
    wd_base = (gnt == state_q) ? wd_q : '0;
    wd_fire = (TIMEOUT != 0) && (gnt != IDLE) && !i_bus_ready && (wd_base == WD_LIMIT);
    wd_d    = '0;
    if ((TIMEOUT != 0) && (gnt != IDLE) && !i_bus_ready && !wd_fire) begin
      wd_d = wd_base + 1'b1;
    end
  end

  // Bus mux and response routing; the non-granted port always sees zeros.
  always_comb begin
    o_bus_rw      = 1'b0;
    o_bus_request = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    o_pa_ready    = 1'b0;
    o_pa_rdata    = '0;
    o_pb_ready    = 1'b0;
    o_pb_rdata    = '0;
    case (gnt)
      GRANT_A: begin
        o_bus_rw      = i_pa_rw;
        o_bus_request = i_pa_request;
        o_bus_address = i_pa_address;
        o_bus_wdata   = i_pa_wdata;
        o_pa_ready    = i_bus_ready | wd_fire;
        o_pa_rdata    = wd_fire ? FAULT_RDATA : i_bus_rdata;
      end
      GRANT_B: begin
        o_bus_rw      = i_pb_rw;
        o_bus_request = i_pb_request;
        o_bus_address = i_pb_address;
        o_bus_wdata   = i_pb_wdata;
        o_pb_ready    = i_bus_ready | wd_fire;
        o_pb_rdata    = wd_fire ? FAULT_RDATA : i_bus_rdata;
      end
      default: ;
    endcase
  end

  // Sticky fault: the first faulting address is kept, and a clear beats a new fault.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (i_fault_clear) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end else if (wd_fire) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = o_bus_address;
    end
  end

  // State, watchdog and fault registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_fault         = fault_q;
  assign o_fault_address = fault_addr_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter (TIMEOUT = 8). Completions are checked
// against a scoreboard of expected {port, rdata} entries.
module tb_cpu_bus_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_pa_rw, i_pa_request, i_pb_rw, i_pb_request;
  logic [31:0] i_pa_address, i_pa_wdata, i_pb_address, i_pb_wdata;
  logic        o_pa_ready, o_pb_ready;
  logic [31:0] o_pa_rdata, o_pb_rdata;
  logic        o_bus_rw, o_bus_request;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_fault;
  logic [31:0] o_fault_address;
  logic        i_fault_clear;

  typedef struct packed {
    logic        b;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_bus_arbiter #(.TIMEOUT(8), .FAULT_RDATA(32'h0000_0000)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_pa_rw(i_pa_rw), .i_pa_request(i_pa_request), .i_pa_address(i_pa_address),
    .i_pa_wdata(i_pa_wdata), .o_pa_ready(o_pa_ready), .o_pa_rdata(o_pa_rdata),
    .i_pb_rw(i_pb_rw), .i_pb_request(i_pb_request), .i_pb_address(i_pb_address),
    .i_pb_wdata(i_pb_wdata), .o_pb_ready(o_pb_ready), .o_pb_rdata(o_pb_rdata),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_fault(o_fault), .o_fault_address(o_fault_address), .i_fault_clear(i_fault_clear)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic b, input logic [31:0] d);
    exp_t e;
    e.b = b;
    e.d = d;
    sb.push_back(e);
  endtask

  // Count wait cycles until port B sees ready (0 = never within the budget).
  task automatic wait_pb(input int clr_at, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clock);
      if (i == clr_at) i_fault_clear = 1'b1;
      #1;
      if (o_pb_ready) begin
        n = i;
        break;
      end
    end
  endtask

  // Completion monitor: every ready must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      #2;
      if (o_pa_ready || o_pb_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ready", {30'b0, o_pb_ready, o_pa_ready}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_port", {30'b0, o_pb_ready, o_pa_ready}, e.b ? 32'd2 : 32'd1);
          chk("sb_rdata", e.b ? o_pb_rdata : o_pa_rdata, e.d);
        end
      end
    end
  end

  initial begin
    int n;
    logic exp_b;
    i_reset = 1'b0;
    i_pa_rw = 1'b0; i_pa_request = 1'b0; i_pa_address = '0; i_pa_wdata = '0;
    i_pb_rw = 1'b0; i_pb_request = 1'b0; i_pb_address = '0; i_pb_wdata = '0;
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_fault_clear = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clock);
    #1;
    chk("rst_bus_request", {31'b0, o_bus_request}, 32'd0);
    chk("rst_bus_address", o_bus_address, 32'd0);
    chk("rst_bus_wdata", o_bus_wdata, 32'd0);
    chk("rst_ready", {30'b0, o_pb_ready, o_pa_ready}, 32'd0);
    chk("rst_fault", {31'b0, o_fault}, 32'd0);
    chk("rst_fault_address", o_fault_address, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;

    // Single port A read
    @(negedge i_clock);
    i_pa_request = 1'b1; i_pa_address = 32'h0000_1000;
    #1 chk("a_rd_req_c0", {31'b0, o_bus_request}, 32'd0);
    @(negedge i_clock);
    #1 chk("a_rd_req_c1", {31'b0, o_bus_request}, 32'd1);
    chk("a_rd_addr", o_bus_address, 32'h0000_1000);
    @(negedge i_clock);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h1234_5678; push(1'b0, 32'h1234_5678);
    #1 chk("a_rd_pb_ready", {31'b0, o_pb_ready}, 32'd0);
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pa_request = 1'b0;
    #1 chk("a_rd_ready_1cyc", {31'b0, o_pa_ready}, 32'd0);

    // Atomic write-back + refill on port A while port B waits
    @(negedge i_clock);
    i_pa_request = 1'b1; i_pa_rw = 1'b1; i_pa_address = 32'h0000_2000; i_pa_wdata = 32'hCAFE_0001;
    @(negedge i_clock);
    i_pb_request = 1'b1; i_pb_address = 32'h0000_0400;
    #1 chk("wb_addr", o_bus_address, 32'h0000_2000);
    chk("wb_rw", {31'b0, o_bus_rw}, 32'd1);
    chk("wb_wdata", o_bus_wdata, 32'hCAFE_0001);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'hAAAA_0000; push(1'b0, 32'hAAAA_0000);
    #1 chk("wb_pb_rdata_zero", o_pb_rdata, 32'd0);
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pa_rw = 1'b0; i_pa_address = 32'h0000_3000;
    #1 chk("refill_addr", o_bus_address, 32'h0000_3000);
    chk("refill_rw", {31'b0, o_bus_rw}, 32'd0);
    @(negedge i_clock);
    #1 chk("refill_addr_held", o_bus_address, 32'h0000_3000);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h55AA_3000; push(1'b0, 32'h55AA_3000);

    // Zero-latency handover to port B
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pa_request = 1'b0;
    #1 chk("handover_addr", o_bus_address, 32'h0000_0400);
    chk("handover_req", {31'b0, o_bus_request}, 32'd1);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h0B0B_0400; push(1'b1, 32'h0B0B_0400);
    #1 chk("handover_pa_ready", {31'b0, o_pa_ready}, 32'd0);
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pb_request = 1'b0;

    // Three rounds of simultaneous requests from IDLE
    for (int r = 0; r < 3; r++) begin
      @(negedge i_clock);
      i_pa_request = 1'b1; i_pa_address = 32'hA000_0000 + r;
      i_pb_request = 1'b1; i_pb_address = 32'hB000_0000 + r;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      exp_b = (r == 1);
`else
      exp_b = 1'b0;
`endif
      @(negedge i_clock);
      i_bus_ready = 1'b1; i_bus_rdata = 32'h7700_0000 + r; push(exp_b, 32'h7700_0000 + r);
      #1 chk("tie_grant_addr", o_bus_address, exp_b ? 32'hB000_0000 + r : 32'hA000_0000 + r);
      @(negedge i_clock);
      i_bus_ready = 1'b0; i_bus_rdata = '0; i_pa_request = 1'b0; i_pb_request = 1'b0;
    end

    // Watchdog: slave never ready
    @(negedge i_clock);
    i_pb_request = 1'b1; i_pb_address = 32'hDEAD_0000; push(1'b1, 32'h0000_0000);
    wait_pb(0, n);
    chk("wd_fire_cycle", n, 32'd9);
    chk("wd_fault_before_edge", {31'b0, o_fault}, 32'd0);
    @(negedge i_clock);
    i_pb_address = 32'hBEEF_0000; push(1'b1, 32'h0000_0000);
    #1 chk("wd_fault_set", {31'b0, o_fault}, 32'd1);
    chk("wd_fault_addr", o_fault_address, 32'hDEAD_0000);
    // One wait cycle of the second timeout has already elapsed.
    wait_pb(0, n);
    chk("wd_refire_cycle", n, 32'd8);
    @(negedge i_clock);
    i_pb_request = 1'b0;
    #1 chk("wd_fault_addr_kept", o_fault_address, 32'hDEAD_0000);
    @(negedge i_clock);
    i_fault_clear = 1'b1;
    @(negedge i_clock);
    i_fault_clear = 1'b0;
    #1 chk("wd_clear_fault", {31'b0, o_fault}, 32'd0);
    chk("wd_clear_addr", o_fault_address, 32'd0);

    // Clear coinciding with a new fault drops the fault
    @(negedge i_clock);
    i_pb_request = 1'b1; i_pb_address = 32'hC0DE_0000; push(1'b1, 32'h0000_0000);
    wait_pb(9, n);
    chk("wd_clr_fire_cycle", n, 32'd9);
    @(negedge i_clock);
    i_fault_clear = 1'b0; i_pb_request = 1'b0;
    #1 chk("wd_clr_prio_fault", {31'b0, o_fault}, 32'd0);
    chk("wd_clr_prio_addr", o_fault_address, 32'd0);

    // Reset asserted mid-grant
    @(negedge i_clock);
    i_pa_request = 1'b1; i_pa_address = 32'h0000_7000;
    @(negedge i_clock);
    #1 chk("rst_mid_granted", {31'b0, o_bus_request}, 32'd1);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'hFFFF_0000; i_reset = 1'b0;
    #1 chk("rst_mid_bus_req", {31'b0, o_bus_request}, 32'd0);
    chk("rst_mid_bus_addr", o_bus_address, 32'd0);
    chk("rst_mid_pa_ready", {31'b0, o_pa_ready}, 32'd0);
    chk("rst_mid_pa_rdata", o_pa_rdata, 32'd0);
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pa_request = 1'b0; i_reset = 1'b1;
    @(negedge i_clock);
    i_pb_request = 1'b1; i_pb_address = 32'h0000_0800;
    #1 chk("post_rst_idle", {31'b0, o_bus_request}, 32'd0);
    @(negedge i_clock);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h0808_0808; push(1'b1, 32'h0808_0808);
    #1 chk("post_rst_b_addr", o_bus_address, 32'h0000_0800);
    chk("post_rst_b_req", {31'b0, o_bus_request}, 32'd1);
    @(negedge i_clock);
    i_bus_ready = 1'b0; i_bus_rdata = '0; i_pb_request = 1'b0;
    repeat (2) @(negedge i_clock);
    #3 chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
